mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 102 ++++++++++
 tb/tb_mem_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory-bus access controller between the CPU control unit/MAR/MDR and a
// handshaked memory. It runs one read or write per request and has a bounded wait for mem_ack.
module mem_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata_out,
  output logic              wr_MDR_Mem,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_cs,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic             op_rd;
  logic [CNT_W-1:0] wait_cnt;

  // Single-process FSM. Every output is a register that is set on the transition into the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_rd      <= 1'b0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata_out  <= '0;
      wr_MDR_Mem <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      done       <= 1'b0;
      wr_MDR_Mem <= 1'b0;
      case (state)
        IDLE: begin
          // A read wins over a simultaneous write. The write is dropped.
          if (rd_req || wr_req) begin
            state    <= ACCESS;
            busy     <= 1'b1;
            mem_cs   <= 1'b1;
            mem_we   <= !rd_req;
            op_rd    <= rd_req;
            mem_addr <= addr_in;
            if (!rd_req) mem_wdata <= wdata_in;
            err      <= 1'b0;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state      <= DONE;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            done       <= 1'b1;
            wr_MDR_Mem <= op_rd;
            if (op_rd) rdata_out <= mem_rdata;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // The last allowed wait cycle has passed, so give up. The counter stops at TIMEOUT.
            state    <= DONE;
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b1;
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl. It runs a directed vector table, a reset-during-access
// sequence, and random transactions that are checked against a transaction-level model.
module tb_mem_ctrl;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 18;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req, wr_req;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              busy, done, err, wr_MDR_Mem, mem_cs, mem_we, mem_ack;
  logic [DATA_W-1:0] rdata_out, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
    .addr_in(addr_in), .wdata_in(wdata_in), .busy(busy), .done(done),
    .err(err), .rdata_out(rdata_out), .wr_MDR_Mem(wr_MDR_Mem),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                waits;      // ack arrives on access cycle waits+1
    logic              stray;      // extra rd_req issued mid-access
    int                exp_cs;     // cycles with mem_cs high
    logic              exp_we;
    logic              exp_wrmdr;
    logic              exp_err;
    logic [DATA_W-1:0] exp_rdata;
    logic [DATA_W-1:0] exp_bus_wdata;
  } vec_t;

  vec_t vecs[7];

  // Model state, kept at transaction level.
  logic [DATA_W-1:0] m_rdata;
  logic [DATA_W-1:0] m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Call at posedge+1 with the DUT idle.
  task automatic run_txn(input vec_t v, input int gap);
    rd_req   = v.rd;
    wr_req   = v.wr;
    addr_in  = v.addr;
    wdata_in = v.wdata;
    mem_ack  = 1'b0;
    @(posedge clk); #1;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    addr_in  = ADDR_W'($urandom);
    wdata_in = DATA_W'($urandom);
    for (int k = 1; k <= v.exp_cs; k++) begin
      chk({v.name, ".cs"},    32'(mem_cs),    32'(1));
      chk({v.name, ".we"},    32'(mem_we),    32'(v.exp_we));
      chk({v.name, ".addr"},  32'(mem_addr),  32'(v.addr));
      chk({v.name, ".wdata"}, 32'(mem_wdata), 32'(v.exp_bus_wdata));
      chk({v.name, ".busy"},  32'(busy),      32'(1));
      chk({v.name, ".done0"}, 32'(done),      32'(0));
      chk({v.name, ".errclr"}, 32'(err),      32'(0));
      mem_ack   = (k == v.waits + 1);
      mem_rdata = mem_ack ? v.rdata : DATA_W'($urandom);
      if (v.stray && k == 1) rd_req = 1'b1;
      @(posedge clk); #1;
      rd_req = 1'b0;
    end
    mem_ack = 1'b0;
    chk({v.name, ".done"},   32'(done),       32'(1));
    chk({v.name, ".wrmdr"},  32'(wr_MDR_Mem), 32'(v.exp_wrmdr));
    chk({v.name, ".err"},    32'(err),        32'(v.exp_err));
    chk({v.name, ".rdata"},  32'(rdata_out),  32'(v.exp_rdata));
    chk({v.name, ".cs_off"}, 32'(mem_cs),     32'(0));
    chk({v.name, ".we_off"}, 32'(mem_we),     32'(0));
    chk({v.name, ".busy_d"}, 32'(busy),       32'(1));
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = DATA_W'($urandom);
    @(posedge clk); #1;
    // Idle gap with spurious acks that must change nothing.
    for (int g = 0; g < gap; g++) begin
      chk({v.name, ".idle_busy"},  32'(busy),       32'(0));
      chk({v.name, ".idle_done"},  32'(done),       32'(0));
      chk({v.name, ".idle_wrmdr"}, 32'(wr_MDR_Mem), 32'(0));
      chk({v.name, ".idle_cs"},    32'(mem_cs),     32'(0));
      chk({v.name, ".idle_err"},   32'(err),        32'(v.exp_err));
      chk({v.name, ".idle_rdata"}, 32'(rdata_out),  32'(v.exp_rdata));
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    vec_t rv;
    logic success;
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr_in = '0; wdata_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    //         name      rd   wr   addr      wdata      rdata      wt st  cs we   wrm  err  exp_rdata  bus_wdata
    vecs[0] = '{"rd0",   1'b1,1'b0,16'h0123,18'h00000,18'h2ABCD, 0, 1'b0, 1,1'b0,1'b1,1'b0,18'h2ABCD,18'h00000};
    vecs[1] = '{"wr3",   1'b0,1'b1,16'hFFFF,18'h15555,18'h00000, 3, 1'b0, 4,1'b1,1'b0,1'b0,18'h2ABCD,18'h15555};
    vecs[2] = '{"rd_to", 1'b1,1'b0,16'h0456,18'h00000,18'h3FFFF,99, 1'b0,15,1'b0,1'b0,1'b1,18'h2ABCD,18'h15555};
    vecs[3] = '{"rd_clr",1'b1,1'b0,16'h0789,18'h00000,18'h00001, 0, 1'b0, 1,1'b0,1'b1,1'b0,18'h00001,18'h15555};
    vecs[4] = '{"both",  1'b1,1'b1,16'h0AAA,18'h3FFFF,18'h12345, 2, 1'b1, 3,1'b0,1'b1,1'b0,18'h12345,18'h15555};
    vecs[5] = '{"wr14",  1'b0,1'b1,16'h1357,18'h0ABCD,18'h00000,14, 1'b0,15,1'b1,1'b0,1'b0,18'h12345,18'h0ABCD};
    vecs[6] = '{"wr_to", 1'b0,1'b1,16'h2468,18'h01234,18'h00000,15, 1'b1,15,1'b1,1'b0,1'b1,18'h12345,18'h01234};

    #3;
    chk("rst.busy",  32'(busy),       32'(0));
    chk("rst.done",  32'(done),       32'(0));
    chk("rst.err",   32'(err),        32'(0));
    chk("rst.cs",    32'(mem_cs),     32'(0));
    chk("rst.we",    32'(mem_we),     32'(0));
    chk("rst.wrmdr", 32'(wr_MDR_Mem), 32'(0));
    chk("rst.rdata", 32'(rdata_out),  32'(0));
    chk("rst.addr",  32'(mem_addr),   32'(0));
    chk("rst.wdata", 32'(mem_wdata),  32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i], 2);

    // Reset during an access: cs and busy fall at once, no done pulse follows.
    rd_req = 1'b1; addr_in = 16'h0BEE;
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst.pre_cs", 32'(mem_cs), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst.cs",    32'(mem_cs),    32'(0));
    chk("arst.busy",  32'(busy),      32'(0));
    chk("arst.done",  32'(done),      32'(0));
    chk("arst.rdata", 32'(rdata_out), 32'(0));
    chk("arst.addr",  32'(mem_addr),  32'(0));
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("arst.nodone", 32'(done), 32'(0));
      chk("arst.idle",   32'(busy), 32'(0));
    end
    m_rdata = '0;
    m_wdata = '0;

    // Random transactions checked against the model.
    for (int n = 0; n < 60; n++) begin
      rv.name  = $sformatf("rnd%0d", n);
      rv.rd    = 1'($urandom_range(0, 1));
      rv.wr    = rv.rd ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.addr  = ADDR_W'($urandom);
      rv.wdata = DATA_W'($urandom);
      rv.rdata = DATA_W'($urandom);
      rv.waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
      rv.stray = 1'($urandom_range(0, 1));
      success  = (rv.waits < TIMEOUT);
      rv.exp_cs        = success ? rv.waits + 1 : TIMEOUT;
      rv.exp_we        = !rv.rd;
      rv.exp_bus_wdata = rv.rd ? m_wdata : rv.wdata;
      if (!rv.rd) m_wdata = rv.wdata;
      if (rv.rd && success) m_rdata = rv.rdata;
      rv.exp_wrmdr = rv.rd && success;
      rv.exp_err   = !success;
      rv.exp_rdata = m_rdata;
      run_txn(rv, int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
